// File: rtl/instr_encoder_if.sv
// Request and instruction-memory write bus for instr_encoder.
// The encoder takes the slave side; the program builder drives the master side.
interface instr_encoder_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_kind;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [25:0]       req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;

  modport master (
    output req_valid, req_kind, req_rs, req_rt, req_rd, req_funct, req_imm,
           req_target, imem_ack,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_kind, req_rs, req_rt, req_rd, req_funct, req_imm,
           req_target, imem_ack,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs field-level instruction requests into 32-bit MIPS words and writes
// them in order into instruction memory over a write/ack port.
//
// state | meaning
// IDLE  | waiting for a request; req_ready = !full
// WRITE | imem_we high, addr/data held until imem_ack
module instr_encoder #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  localparam logic [2:0] KIND_R   = 3'd0;
  localparam logic [2:0] KIND_ORI = 3'd1;
  localparam logic [2:0] KIND_LW  = 3'd2;
  localparam logic [2:0] KIND_SW  = 3'd3;
  localparam logic [2:0] KIND_BEQ = 3'd4;
  localparam logic [2:0] KIND_J   = 3'd5;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;

  // Encoder: only the funct codes ALUControl decodes are legal R-types.
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (bus.req_kind)
      KIND_R: begin
        enc_word = {OP_R, bus.req_rs, bus.req_rt, bus.req_rd, 5'b00000, bus.req_funct};
        case (bus.req_funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: enc_legal = 1'b1;
          default:                               enc_legal = 1'b0;
        endcase
      end
      KIND_ORI: enc_word = {OP_ORI, bus.req_rs, bus.req_rt, bus.req_imm};
      KIND_LW:  enc_word = {OP_LW,  bus.req_rs, bus.req_rt, bus.req_imm};
      KIND_SW:  enc_word = {OP_SW,  bus.req_rs, bus.req_rt, bus.req_imm};
      KIND_BEQ: enc_word = {OP_BEQ, bus.req_rs, bus.req_rt, bus.req_imm};
      KIND_J:   enc_word = {OP_J,   bus.req_target};
      default:  enc_legal = 1'b0;
    endcase
  end

  // count saturates at 2^ADDR_W, so its top bit alone means full.
  assign full          = count[ADDR_W];
  assign bus.req_ready = (state == IDLE) && !full;
  assign accept        = bus.req_valid && bus.req_ready && !clear;
  assign bus.imem_we   = (state == WRITE);
  assign bus.imem_addr = addr_q;
  assign bus.imem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= BASE;
      wdata_q <= '0;
      count   <= '0;
      err     <= 1'b0;
    end else if (clear) begin
      // An in-flight write is abandoned even if imem_ack is high now.
      state  <= IDLE;
      addr_q <= BASE;
      count  <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (enc_legal) begin
              wdata_q <= enc_word;
              state   <= WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.imem_ack) begin
            addr_q <= addr_q + 1'b1;
            count  <= count + 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
